// File: rtl/instr_seq.sv
// Instruction sequencer: FIFO-buffered fetch, decode and repeat expansion into datapath commands.
// Optional issued-command counter is enabled with `define INSTR_SEQ_STATS_EN.
module instr_seq #(
    parameter int INSTR_W     = 32,
    parameter int DEPTH       = 8,
    parameter int OP_W        = 4,
    parameter int RPT_W       = 8,
    parameter int ADDR_W      = 12,
    parameter int ADDR_STRIDE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       in_ready,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [OP_W-1:0]            cmd_op,
    output logic [ADDR_W-1:0]          cmd_addr,
    output logic                       cmd_start,
    output logic                       cmd_last,
    input  logic                       done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic [31:0]                cmd_total
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int FIELD_W = 2 + OP_W + RPT_W + ADDR_W;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ADDR_STRIDE);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    logic [FIELD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               start_q, start_d;
    logic               last_q, last_d;
    logic               lflag_q, lflag_d;
    logic [RPT_W-1:0]   rpt_q, rpt_d;
    logic [RPT_W-1:0]   k_q, k_d;

    logic               full, push, pop;
    logic [FIELD_W-1:0] head;
    logic [OP_W-1:0]    h_op;
    logic [RPT_W-1:0]   h_rpt;
    logic [ADDR_W-1:0]  h_base;

    assign full   = (count_q == FULL_CNT);
    assign push   = in_valid && !full;
    assign head   = mem_q[rd_ptr_q];
    assign h_op   = head[2 +: OP_W];
    assign h_rpt  = head[2+OP_W +: RPT_W];
    assign h_base = head[2+OP_W+RPT_W +: ADDR_W];

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        op_d       = op_q;
        addr_d     = addr_q;
        start_d    = start_q;
        last_d     = last_q;
        lflag_d    = lflag_q;
        rpt_d      = rpt_q;
        k_d        = k_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (in_valid && full);
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    // NOPs are consumed here without leaving IDLE
                    if (h_op != '0) begin
                        state_d = S_ISSUE;
                        valid_d = 1'b1;
                        op_d    = h_op;
                        addr_d  = h_base;
                        start_d = head[0];
                        last_d  = head[1] && (h_rpt == '0);
                        lflag_d = head[1];
                        rpt_d   = h_rpt;
                        k_d     = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    if (k_q != rpt_q) begin
                        k_d     = k_q + 1'b1;
                        addr_d  = addr_q + STRIDE;
                        start_d = 1'b0;
                        last_d  = lflag_q && ((k_q + 1'b1) == rpt_q);
                    end else begin
                        state_d = lflag_q ? S_WAIT : S_IDLE;
                        valid_d = 1'b0;
                        op_d    = '0;
                        addr_d  = '0;
                        start_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_instr[FIELD_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            op_q       <= '0;
            addr_q     <= '0;
            start_q    <= 1'b0;
            last_q     <= 1'b0;
            lflag_q    <= 1'b0;
            rpt_q      <= '0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            start_q    <= start_d;
            last_q     <= last_d;
            lflag_q    <= lflag_d;
            rpt_q      <= rpt_d;
            k_q        <= k_d;
        end
    end

`ifdef INSTR_SEQ_STATS_EN
    logic [31:0] total_q, total_d;

    always_comb total_d = total_q + ((valid_q && cmd_ready) ? 32'd1 : 32'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) total_q <= '0;
        else      total_q <= total_d;
    end

    assign cmd_total = total_q;
`else
    assign cmd_total = '0;
`endif

    assign in_ready   = !full;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign cmd_valid  = valid_q;
    assign cmd_op     = op_q;
    assign cmd_addr   = addr_q;
    assign cmd_start  = start_q;
    assign cmd_last   = last_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq: vector table for issue/done timing,
// hand sequences for backpressure, full FIFO, reset and NOP/address wrap.
module tb_instr_seq;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [11:0] cmd_addr;
    logic        cmd_start;
    logic        cmd_last;
    logic        done;
    logic        busy;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [31:0] cmd_total;

    int errors = 0;
    int checks = 0;

`ifdef INSTR_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    instr_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_start  (cmd_start),
        .cmd_last   (cmd_last),
        .done       (done),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .cmd_total  (cmd_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic        rdy;
        logic        dn;
        logic        ev;
        logic [3:0]  eop;
        logic [11:0] eaddr;
        logic        es;
        logic        el;
        logic [3:0]  ecnt;
        logic        eb;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [31:0] mk(input logic s, input logic l,
                                       input logic [3:0] op, input logic [7:0] r,
                                       input logic [11:0] b);
        mk = {6'b0, b, r, op, l, s};
    endfunction

    function automatic vec_t mkv(input logic iv, input logic [31:0] instr,
                                 input logic rdy, input logic dn, input logic ev,
                                 input logic [3:0] eop, input logic [11:0] eaddr,
                                 input logic es, input logic el,
                                 input logic [3:0] ecnt, input logic eb);
        vec_t v;
        v.iv = iv; v.instr = instr; v.rdy = rdy; v.dn = dn;
        v.ev = ev; v.eop = eop; v.eaddr = eaddr; v.es = es; v.el = el;
        v.ecnt = ecnt; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_cmd(input string tag, input logic v, input logic [3:0] op,
                           input logic [11:0] a, input logic s, input logic l);
        chk({tag, " valid"}, {31'b0, cmd_valid}, {31'b0, v});
        chk({tag, " op"}, {28'b0, cmd_op}, {28'b0, op});
        chk({tag, " addr"}, {20'b0, cmd_addr}, {20'b0, a});
        chk({tag, " start"}, {31'b0, cmd_start}, {31'b0, s});
        chk({tag, " last"}, {31'b0, cmd_last}, {31'b0, l});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_cmd(tag, 1'b0, 4'd0, 12'd0, 1'b0, 1'b0);
        chk({tag, " count"}, {28'b0, fifo_count}, 32'd0);
        chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, " busy"}, {31'b0, busy}, 32'd0);
        chk({tag, " overflow"}, {31'b0, overflow}, 32'd0);
        chk({tag, " total"}, cmd_total, 32'd0);
    endtask

    initial begin
        logic [31:0] i1, i2, i3;
        int n;

        i1 = mk(1'b1, 1'b0, 4'd3, 8'd2, 12'h100);
        i2 = mk(1'b0, 1'b1, 4'd5, 8'd0, 12'h020);
        i3 = mk(1'b1, 1'b1, 4'd6, 8'd1, 12'h030);
        //            iv    instr rdy dn  ev  op    addr     s  l  cnt  busy
        tbl[0]  = mkv(1'b1, i1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 4'd1, 1);
        tbl[1]  = mkv(1'b0, 0,  1, 0, 1, 4'd3, 12'h100, 1, 0, 4'd0, 1);
        tbl[2]  = mkv(1'b0, 0,  1, 0, 1, 4'd3, 12'h101, 0, 0, 4'd0, 1);
        tbl[3]  = mkv(1'b0, 0,  1, 0, 1, 4'd3, 12'h102, 0, 0, 4'd0, 1);
        tbl[4]  = mkv(1'b0, 0,  1, 0, 0, 4'd0, 12'h000, 0, 0, 4'd0, 0);
        tbl[5]  = mkv(1'b0, 0,  1, 0, 0, 4'd0, 12'h000, 0, 0, 4'd0, 0);
        tbl[6]  = mkv(1'b1, i2, 1, 0, 0, 4'd0, 12'h000, 0, 0, 4'd1, 1);
        tbl[7]  = mkv(1'b1, i3, 1, 0, 1, 4'd5, 12'h020, 0, 1, 4'd1, 1);
        tbl[8]  = mkv(1'b0, 0,  1, 0, 0, 4'd0, 12'h000, 0, 0, 4'd1, 1);
        tbl[9]  = mkv(1'b0, 0,  1, 0, 0, 4'd0, 12'h000, 0, 0, 4'd1, 1);
        tbl[10] = mkv(1'b0, 0,  1, 0, 0, 4'd0, 12'h000, 0, 0, 4'd1, 1);
        tbl[11] = mkv(1'b0, 0,  1, 1, 0, 4'd0, 12'h000, 0, 0, 4'd1, 1);
        tbl[12] = mkv(1'b0, 0,  1, 0, 1, 4'd6, 12'h030, 1, 0, 4'd0, 1);
        tbl[13] = mkv(1'b0, 0,  1, 0, 1, 4'd6, 12'h031, 0, 1, 4'd0, 1);
        tbl[14] = mkv(1'b0, 0,  1, 0, 0, 4'd0, 12'h000, 0, 0, 4'd0, 1);
        tbl[15] = mkv(1'b0, 0,  1, 1, 0, 4'd0, 12'h000, 0, 0, 4'd0, 0);
        tbl[16] = mkv(1'b0, 0,  1, 1, 0, 4'd0, 12'h000, 0, 0, 4'd0, 0);

        rst = 1'b0; in_valid = 1'b0; in_instr = '0; cmd_ready = 1'b0; done = 1'b0;
        #1;
        chk_reset_vals("por");
        cyc();
        cyc();
        rst = 1'b1;

        // basic issue, last flag and done timing
        for (int i = 0; i < 17; i++) begin
            in_valid  = tbl[i].iv;
            in_instr  = tbl[i].instr;
            cmd_ready = tbl[i].rdy;
            done      = tbl[i].dn;
            cyc();
            chk_cmd($sformatf("v%0d", i), tbl[i].ev, tbl[i].eop, tbl[i].eaddr,
                    tbl[i].es, tbl[i].el);
            chk($sformatf("v%0d count", i), {28'b0, fifo_count}, {28'b0, tbl[i].ecnt});
            chk($sformatf("v%0d busy", i), {31'b0, busy}, {31'b0, tbl[i].eb});
        end
        in_valid = 1'b0; done = 1'b0;
        chk("total after table", cmd_total, STATS ? 32'd6 : 32'd0);

        // backpressure mid-instruction
        in_valid = 1'b1; in_instr = mk(1'b1, 1'b1, 4'd7, 8'd2, 12'h200);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk_cmd("bp first", 1'b1, 4'd7, 12'h200, 1'b1, 1'b0);
        cyc();
        chk_cmd("bp second", 1'b1, 4'd7, 12'h201, 1'b0, 1'b0);
        cmd_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cyc();
            chk_cmd($sformatf("bp hold%0d", j), 1'b1, 4'd7, 12'h201, 1'b0, 1'b0);
        end
        cmd_ready = 1'b1;
        cyc();
        chk_cmd("bp third", 1'b1, 4'd7, 12'h202, 1'b0, 1'b1);
        cyc();
        chk_cmd("bp waitdone", 1'b0, 4'd0, 12'h000, 1'b0, 1'b0);
        done = 1'b1;
        cyc();
        done = 1'b0;
        chk("bp busy", {31'b0, busy}, 32'd0);
        chk("bp total", cmd_total, STATS ? 32'd9 : 32'd0);

        // full FIFO while parked in WAIT_DONE
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        in_valid = 1'b1; in_instr = mk(1'b0, 1'b1, 4'd2, 8'd0, 12'h010);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk_cmd("full lead", 1'b1, 4'd2, 12'h010, 1'b0, 1'b1);
        cyc();
        chk("full in wait", {31'b0, cmd_valid}, 32'd0);
        for (int j = 0; j < 9; j++) begin
            in_valid = 1'b1;
            in_instr = mk(1'b0, 1'b0, 4'd1, 8'd0, 12'h040 + 12'(j));
            cyc();
            if (j == 7) begin
                chk("full count8", {28'b0, fifo_count}, 32'd8);
                chk("full in_ready", {31'b0, in_ready}, 32'd0);
                chk("full ovf pre", {31'b0, overflow}, 32'd0);
            end
        end
        in_valid = 1'b0;
        chk("full ovf set", {31'b0, overflow}, 32'd1);
        chk("full count kept", {28'b0, fifo_count}, 32'd8);
        cyc();
        chk("full ovf sticky", {31'b0, overflow}, 32'd1);
        chk("full total", cmd_total, STATS ? 32'd1 : 32'd0);
        chk("full cmd_valid", {31'b0, cmd_valid}, 32'd0);
        done = 1'b1;
        cyc();
        done = 1'b0;
        n = 0;
        for (int j = 0; j < 30; j++) begin
            cyc();
            if (cmd_valid && cmd_ready) begin
                chk($sformatf("drain addr%0d", n), {20'b0, cmd_addr},
                    32'h40 + 32'(n));
                n++;
            end
        end
        chk("drain n", 32'(n), 32'd8);
        chk("drain ovf", {31'b0, overflow}, 32'd1);
        chk("drain total", cmd_total, STATS ? 32'd9 : 32'd0);

        // reset during ISSUE with three queued
        cmd_ready = 1'b0;
        in_valid = 1'b1; in_instr = mk(1'b1, 1'b1, 4'd4, 8'd5, 12'h300);
        cyc();
        in_instr = mk(1'b0, 1'b0, 4'd8, 8'd0, 12'h400);
        cyc();
        in_instr = mk(1'b0, 1'b0, 4'd9, 8'd0, 12'h500);
        cyc();
        in_instr = mk(1'b0, 1'b0, 4'd10, 8'd0, 12'h600);
        cyc();
        in_valid = 1'b0;
        chk_cmd("rst pre", 1'b1, 4'd4, 12'h300, 1'b1, 1'b0);
        chk("rst pre count", {28'b0, fifo_count}, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("rst async");
        cyc();
        rst = 1'b1;
        cmd_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cyc();
            chk($sformatf("rst idle%0d", j), {31'b0, cmd_valid | busy}, 32'd0);
        end

        // NOP then address wrap
        in_valid = 1'b1; in_instr = mk(1'b1, 1'b1, 4'd0, 8'd3, 12'h055);
        cyc();
        in_instr = mk(1'b0, 1'b0, 4'd1, 8'd3, 12'hFFE);
        cyc();
        in_valid = 1'b0;
        chk_cmd("nop skip", 1'b0, 4'd0, 12'h000, 1'b0, 1'b0);
        chk("nop count", {28'b0, fifo_count}, 32'd1);
        cyc();
        chk_cmd("wrap0", 1'b1, 4'd1, 12'hFFE, 1'b0, 1'b0);
        cyc();
        chk_cmd("wrap1", 1'b1, 4'd1, 12'hFFF, 1'b0, 1'b0);
        cyc();
        chk_cmd("wrap2", 1'b1, 4'd1, 12'h000, 1'b0, 1'b0);
        cyc();
        chk_cmd("wrap3", 1'b1, 4'd1, 12'h001, 1'b0, 1'b0);
        cyc();
        chk_cmd("wrap end", 1'b0, 4'd0, 12'h000, 1'b0, 1'b0);
        chk("wrap busy", {31'b0, busy}, 32'd0);
        chk("wrap total", cmd_total, STATS ? 32'd4 : 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
